// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS core.
// Holds the PC, requests instruction words from instruction memory and hands
// the fetched instruction together with its PC+4 to decode.
//
//   * bubble   (hazard unit) freezes the PC and IF/ID. A word that arrives
//              while frozen is parked in a one-entry skid buffer (HELD state).
//   * redirect (EX stage) flushes IF/ID, drops any parked word and reloads
//              the PC from redirect_pc.
//
// Priority per cycle: reset > redirect > bubble > normal fetch.
//
// Optional feature macro: FETCH_STALL_CNT_EN
//   When defined, the stall_count port and its saturating bubble-cycle
//   counter are present. When undefined, both are absent.
//
// Parameters
//   RESET_PC     PC value loaded on reset
//
// Ports
//   clk          in   1   rising-edge clock
//   rst_n        in   1   synchronous active-low reset
//   bubble       in   1   hazard stall: hold PC and IF/ID
//   redirect     in   1   taken branch/jump: flush IF/ID and reload PC
//   redirect_pc  in  32   new PC, valid while redirect=1
//   imem_req     out  1   fetch request (state==FETCH and not in reset)
//   imem_addr    out 32   fetch address (= PC)
//   imem_ready   in   1   imem_rdata valid for imem_addr this cycle
//   imem_rdata   in  32   instruction word
//   id_instr     out 32   IF/ID instruction (0 = NOP when invalid)
//   id_pc4       out 32   IF/ID PC+4 of id_instr
//   id_valid     out  1   IF/ID holds a real instruction
//   stall_count  out 32   bubble-cycle counter (FETCH_STALL_CNT_EN only)
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bubble,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4,
  output logic        id_valid
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_HELD  = 1'b1
  } state_t;

  // PC advance; 32-bit modulo, low two bits carried through untouched.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc_in);
    pc_inc = pc_in + 32'd4;
  endfunction

  state_t      state_r;
  state_t      state_s;
  logic [31:0] pc_r;
  logic [31:0] pc_s;
  logic [31:0] hold_instr_r;
  logic [31:0] hold_instr_s;
  logic [31:0] id_instr_s;
  logic [31:0] id_pc4_s;
  logic        id_valid_s;
  logic [31:0] pc_plus4_s;

  assign pc_plus4_s = pc_inc(pc_r);

  // Memory-side outputs depend only on registers and rst_n, so the request
  // drops combinationally as soon as reset is asserted.
  assign imem_req  = (state_r == ST_FETCH) && rst_n;
  assign imem_addr = pc_r;

  // Next-state and next-register values; everything holds unless changed.
  always_comb begin
    state_s      = state_r;
    pc_s         = pc_r;
    hold_instr_s = hold_instr_r;
    id_instr_s   = id_instr;
    id_pc4_s     = id_pc4;
    id_valid_s   = id_valid;

    if (redirect) begin
      // Flush: any word returning this cycle belongs to the wrong path and
      // the skid buffer is dropped as well.
      pc_s         = redirect_pc;
      hold_instr_s = 32'h0000_0000;
      id_instr_s   = 32'h0000_0000;
      id_pc4_s     = 32'h0000_0000;
      id_valid_s   = 1'b0;
      state_s      = ST_FETCH;
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (bubble) begin
            // Decode is frozen; park a completing word so it is neither
            // lost nor re-fetched.
            if (imem_ready) begin
              hold_instr_s = imem_rdata;
              state_s      = ST_HELD;
            end else begin
              state_s      = ST_FETCH;
            end
          end else begin
            if (imem_ready) begin
              id_instr_s = imem_rdata;
              id_pc4_s   = pc_plus4_s;
              id_valid_s = 1'b1;
              pc_s       = pc_plus4_s;
            end else begin
              // Memory not ready: feed decode a NOP, retry the same PC.
              id_instr_s = 32'h0000_0000;
              id_pc4_s   = 32'h0000_0000;
              id_valid_s = 1'b0;
            end
          end
        end
        ST_HELD: begin
          if (bubble) begin
            state_s = ST_HELD;
          end else begin
            // Release the parked word; the next request goes out one cycle
            // later, from FETCH.
            id_instr_s = hold_instr_r;
            id_pc4_s   = pc_plus4_s;
            id_valid_s = 1'b1;
            pc_s       = pc_plus4_s;
            state_s    = ST_FETCH;
          end
        end
        default: begin
          state_s    = ST_FETCH;
          id_instr_s = 32'h0000_0000;
          id_pc4_s   = 32'h0000_0000;
          id_valid_s = 1'b0;
        end
      endcase
    end
  end

  // State, PC, skid buffer and IF/ID registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_FETCH;
      pc_r         <= RESET_PC;
      hold_instr_r <= 32'h0000_0000;
      id_instr     <= 32'h0000_0000;
      id_pc4       <= 32'h0000_0000;
      id_valid     <= 1'b0;
    end else begin
      state_r      <= state_s;
      pc_r         <= pc_s;
      hold_instr_r <= hold_instr_s;
      id_instr     <= id_instr_s;
      id_pc4       <= id_pc4_s;
      id_valid     <= id_valid_s;
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt_r;

  // Saturating count of bubble edges; redirect edges are not stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_r <= 32'h0000_0000;
    end else if (bubble && !redirect && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_count = stall_cnt_r;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] MASK   = 32'hA5A5_A5A5;
  localparam int          NVEC   = 20;

  logic        clk;
  logic        rst_n;
  logic        bubble;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] id_instr;
  logic [31:0] id_pc4;
  logic        id_valid;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_count;
`endif

  int checks = 0;
  int errors = 0;

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bubble      (bubble),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .id_instr    (id_instr),
    .id_pc4      (id_pc4),
    .id_valid    (id_valid)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stall_count (stall_count)
`endif
  );

  // Instruction memory model: word at address A is A ^ MASK.
  assign imem_rdata = imem_addr ^ MASK;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst_n;
    logic        bubble;
    logic        redirect;
    logic [31:0] rpc;
    logic        ready;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic        e_valid;
    logic [31:0] e_stall;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic e_req, input logic [31:0] e_addr,
                          input logic [31:0] e_instr, input logic [31:0] e_pc4,
                          input logic e_valid, input logic [31:0] e_stall);
    chk({tag, " req"},   {31'd0, imem_req}, {31'd0, e_req});
    chk({tag, " addr"},  imem_addr, e_addr);
    chk({tag, " instr"}, id_instr, e_instr);
    chk({tag, " pc4"},   id_pc4, e_pc4);
    chk({tag, " valid"}, {31'd0, id_valid}, {31'd0, e_valid});
`ifdef FETCH_STALL_CNT_EN
    chk({tag, " stall"}, stall_count, e_stall);
`else
    if (e_stall == 32'hFFFF_FFFF) begin
      $display("note: unexpected stall expectation in %s", tag);
    end
`endif
  endtask

  task automatic drive(input logic r, input logic b, input logic rd, input logic [31:0] rp,
                       input logic rdy);
    rst_n       = r;
    bubble      = b;
    redirect    = rd;
    redirect_pc = rp;
    imem_ready  = rdy;
  endtask

  initial begin
    //          rst  bub  red  rpc            rdy  req  addr           instr          pc4            val  stall
    vecs[0]  = '{1'b0,1'b0,1'b0,32'h0,        1'b1,1'b0,32'h0040_0000,32'h0,         32'h0,         1'b0,32'd0};
    vecs[1]  = '{1'b1,1'b0,1'b0,32'h0,        1'b1,1'b1,32'h0040_0004,32'hA5E5_A5A5,32'h0040_0004,1'b1,32'd0};
    vecs[2]  = '{1'b1,1'b0,1'b0,32'h0,        1'b1,1'b1,32'h0040_0008,32'hA5E5_A5A1,32'h0040_0008,1'b1,32'd0};
    vecs[3]  = '{1'b1,1'b1,1'b0,32'h0,        1'b1,1'b0,32'h0040_0008,32'hA5E5_A5A1,32'h0040_0008,1'b1,32'd1};
    vecs[4]  = '{1'b1,1'b1,1'b0,32'h0,        1'b1,1'b0,32'h0040_0008,32'hA5E5_A5A1,32'h0040_0008,1'b1,32'd2};
    vecs[5]  = '{1'b1,1'b1,1'b0,32'h0,        1'b1,1'b0,32'h0040_0008,32'hA5E5_A5A1,32'h0040_0008,1'b1,32'd3};
    vecs[6]  = '{1'b1,1'b0,1'b0,32'h0,        1'b1,1'b1,32'h0040_000C,32'hA5E5_A5AD,32'h0040_000C,1'b1,32'd3};
    vecs[7]  = '{1'b1,1'b0,1'b0,32'h0,        1'b1,1'b1,32'h0040_0010,32'hA5E5_A5A9,32'h0040_0010,1'b1,32'd3};
    vecs[8]  = '{1'b1,1'b0,1'b0,32'h0,        1'b0,1'b1,32'h0040_0010,32'h0,         32'h0,         1'b0,32'd3};
    vecs[9]  = '{1'b1,1'b0,1'b0,32'h0,        1'b0,1'b1,32'h0040_0010,32'h0,         32'h0,         1'b0,32'd3};
    vecs[10] = '{1'b1,1'b0,1'b0,32'h0,        1'b1,1'b1,32'h0040_0014,32'hA5E5_A5B5,32'h0040_0014,1'b1,32'd3};
    vecs[11] = '{1'b1,1'b1,1'b1,32'h0000_0100,1'b1,1'b1,32'h0000_0100,32'h0,         32'h0,         1'b0,32'd3};
    vecs[12] = '{1'b1,1'b0,1'b0,32'h0,        1'b1,1'b1,32'h0000_0104,32'hA5A5_A4A5,32'h0000_0104,1'b1,32'd3};
    vecs[13] = '{1'b1,1'b1,1'b0,32'h0,        1'b1,1'b0,32'h0000_0104,32'hA5A5_A4A5,32'h0000_0104,1'b1,32'd4};
    vecs[14] = '{1'b0,1'b1,1'b0,32'h0,        1'b1,1'b0,32'h0040_0000,32'h0,         32'h0,         1'b0,32'd0};
    vecs[15] = '{1'b1,1'b0,1'b0,32'h0,        1'b1,1'b1,32'h0040_0004,32'hA5E5_A5A5,32'h0040_0004,1'b1,32'd0};
    vecs[16] = '{1'b1,1'b1,1'b0,32'h0,        1'b0,1'b1,32'h0040_0004,32'hA5E5_A5A5,32'h0040_0004,1'b1,32'd1};
    vecs[17] = '{1'b1,1'b0,1'b0,32'h0,        1'b1,1'b1,32'h0040_0008,32'hA5E5_A5A1,32'h0040_0008,1'b1,32'd1};
    vecs[18] = '{1'b1,1'b0,1'b1,32'hFFFF_FFFC,1'b1,1'b1,32'hFFFF_FFFC,32'h0,         32'h0,         1'b0,32'd1};
    vecs[19] = '{1'b1,1'b0,1'b0,32'h0,        1'b1,1'b1,32'h0000_0000,32'h5A5A_5A59,32'h0000_0000,1'b1,32'd1};

    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    // Table: inputs held across one rising edge, outputs checked 1 time unit later.
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].rst_n, vecs[i].bubble, vecs[i].redirect, vecs[i].rpc, vecs[i].ready);
      @(posedge clk);
      #1;
      chk_outs($sformatf("v%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_instr,
               vecs[i].e_pc4, vecs[i].e_valid, vecs[i].e_stall);
    end

    // Sequence A: enter HELD at PC 0, then redirect while still bubbled.
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    @(posedge clk);
    #1;
    chk_outs("seqA held", 1'b0, 32'h0000_0000, 32'h5A5A_5A59, 32'h0000_0000, 1'b1, 32'd2);
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0200, 1'b1);
    @(posedge clk);
    #1;
    chk_outs("seqA redirect", 1'b1, 32'h0000_0200, 32'h0, 32'h0, 1'b0, 32'd2);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    @(posedge clk);
    #1;
    chk_outs("seqA fetch", 1'b1, 32'h0000_0204, 32'hA5A5_A7A5, 32'h0000_0204, 1'b1, 32'd2);

    // Sequence B: request drops combinationally when reset asserts in FETCH.
    chk("seqB req before rst", {31'd0, imem_req}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    #1;
    chk("seqB req comb rst", {31'd0, imem_req}, 32'd0);
    @(posedge clk);
    #1;
    chk_outs("seqB reset", 1'b0, RST_PC, 32'h0, 32'h0, 1'b0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    #1;
    chk("seqB req after rst", {31'd0, imem_req}, 32'd1);
    @(posedge clk);
    #1;
    chk_outs("seqB resume", 1'b1, 32'h0040_0004, 32'hA5E5_A5A5, 32'h0040_0004, 1'b1, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the 5-stage MIPS core. It holds the PC, issues requests to instruction memory, and presents the fetched instruction and PC+4 to decode. It consumes `bubble` from the hazard unit by freezing the PC and IF/ID contents. It consumes `redirect` from EX by flushing IF/ID and reloading the PC.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset; synchronous, active-low
- `bubble`  in  1  hazard stall; hold PC and IF/ID
- `redirect`  in  1  taken branch/jump from EX; flush and reload PC
- `redirect_pc`  in  32  new PC, valid when `redirect`=1
- `imem_req`  out  1  fetch request to instruction memory
- `imem_addr`  out  32  fetch address (= PC)
- `imem_ready`  in  1  `imem_rdata` valid for `imem_addr` this cycle
- `imem_rdata`  in  32  instruction word
- `id_instr`  out  32  IF/ID instruction (0x0000_0000 = NOP when invalid)
- `id_pc4`  out  32  IF/ID PC+4 of `id_instr`
- `id_valid`  out  1  IF/ID holds a real instruction
- `stall_count`  out  32  bubble-cycle counter; present only with `FETCH_STALL_CNT_EN`

## Operation
- State register: FETCH, HELD. Registers: `pc`, `hold_instr` (skid buffer), IF/ID (`id_instr`, `id_pc4`, `id_valid`).
- Reset (`rst_n`=0 at edge): `pc`=RESET_PC, state=FETCH, `id_instr`=0, `id_pc4`=0, `id_valid`=0, `hold_instr`=0, `stall_count`=0.
- `imem_req` = (state==FETCH) && `rst_n`; `imem_addr` = `pc` at all times. Both are combinational from registers and `rst_n` only.
- Priority per cycle: reset > redirect > bubble > normal.
- redirect=1:
  - `pc`<=`redirect_pc`; IF/ID <= {0, 0, valid=0}; state<=FETCH.
  - Any `imem_ready`/`imem_rdata` this cycle is discarded, and `hold_instr` is discarded.
  - Redirect wins over a simultaneous `bubble`.
- FETCH, bubble=0:
  - If `imem_ready`=1: IF/ID <= {`imem_rdata`, `pc`+4, 1}; `pc`<=`pc`+4.
  - If `imem_ready`=0: IF/ID <= {0, 0, 0} (NOP inserted into decode); `pc` is unchanged.
- FETCH, bubble=1:
  - IF/ID and `pc` are unchanged.
  - If `imem_ready`=1: `hold_instr`<=`imem_rdata`; state<=HELD. The fetched word is not lost and is not re-fetched.
- HELD:
  - `imem_req`=0.
  - While bubble=1: all state is held.
  - When bubble=0: IF/ID <= {`hold_instr`, `pc`+4, 1}; `pc`<=`pc`+4; state<=FETCH.
- PC arithmetic: 32-bit modulo; 0xFFFF_FFFC+4 wraps to 0x0000_0000. Low two bits are carried through unmodified and never checked.
- Memory contract: `imem_ready` qualifies data only for the address presented in the same cycle. The memory must tolerate the address changing without completion (redirect).

## Timing
- Zero-wait memory: one instruction per cycle. The word at PC appears on `id_instr` one edge after `imem_ready` is sampled high.
- `bubble` takes effect at the same edge it is sampled. The held IF/ID is visible for every cycle `bubble`=1.
- Leaving HELD: the buffered instruction reaches IF/ID on the first edge with `bubble`=0. The next fetch request goes out in the following cycle, so there is a 1-cycle request gap.
- Redirect: first request to `redirect_pc` is in the cycle after the redirect edge. `id_valid`=0 for at least one cycle.
- `rst_n` low mid-operation: all state returns to reset values at that edge regardless of `bubble`/`redirect`. `imem_req`=0 combinationally while `rst_n`=0.

## Configuration
- `FETCH_STALL_CNT_EN` defined:
  - Port `stall_count` exists.
  - It increments by 1 on each edge where `rst_n`=1, `bubble`=1 and `redirect`=0.
  - It saturates at 0xFFFF_FFFF and resets to 0.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset with RESET_PC=0x0040_0000, `imem_ready` tied 1, rdata=addr^0xA5A5A5A5 -> `imem_addr` 0x0040_0000, 0x0040_0004, …; `id_pc4`=0x0040_0004 with `id_instr`=0xA5E5A5A5 one edge after first request; `id_valid`=1 every cycle.
- `bubble`=1 for 3 cycles mid-stream with `imem_ready`=1 -> IF/ID and `pc` frozen for 3 cycles; state HELD, `imem_req`=0; after release the captured word appears, no address skipped or repeated; `stall_count` +3.
- `imem_ready`=0 for 2 cycles, `bubble`=0 -> `id_valid`=0, `id_instr`=0 for 2 cycles, `imem_addr` constant, then resumes.
- `redirect`=1, `redirect_pc`=0x0000_0100, simultaneous `bubble`=1 and `imem_ready`=1 -> next cycle `imem_addr`=0x100, `id_valid`=0, `stall_count` unchanged.
- `rst_n`=0 while in HELD -> next cycle state FETCH, `pc`=RESET_PC, IF/ID all 0, `imem_req`=0 during reset, `hold_instr` discarded.
- PC=0xFFFF_FFFC fetch completes -> `id_pc4`=0x0000_0000, next `imem_addr`=0x0000_0000.
